onehot_event_encoder: RTL and testbench

- Encoder counterpart to the team's 3-to-8 one-hot decoder: converts one-hot/multi-hot event lines back into a binary index.
- Latches events on up to 8 request lines into a sticky pending register.
- Serves pending events one at a time as a 3-bit binary code with a valid/ready handshake.
- Sits between board inputs (debounced buttons/switches) and downstream logic that consumes one event index per transaction, e.g. a 7-segment display driver or the decoder itself.

---
 rtl/onehot_event_encoder.sv | 94 +++++++++
 tb/tb_onehot_event_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder: latches request lines into a sticky pending vector and serves them as binary codes over valid/ready
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   req_i      [N-1:0] event request lines, each high bit marks that index pending
//   ready_i    consumer accepts code_o when valid_o & ready_i at a rising edge
//   code_o     [W-1:0] registered binary index being offered
//   valid_o    registered, code_o is valid and held stable
//   pending_o  [N-1:0] registered sticky pending vector
//   overrun_o  sticky flag, a request arrived for an index already pending
// Build option: define ROUND_ROBIN_EN for round-robin selection; default is lowest-index priority.
module onehot_event_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         ready_i,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    output logic [N-1:0] pending_o,
    output logic         overrun_o
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t       state_q;
    logic [N-1:0] pending_q, pending_d, clr;
    logic [W-1:0] code_q, sel;
    logic         valid_q, overrun_q, overrun_d, accept;

    assign accept    = valid_q & ready_i;
    assign clr       = accept ? (N'(1) << code_q) : '0;
    // OR-ing req after the clear lets a same-cycle request keep the bit set
    assign pending_d = (pending_q & ~clr) | req_i;
    assign overrun_d = overrun_q | (|(req_i & pending_q & ~clr));

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr_q, idx;
    logic         found;
    // search starts just past the last accepted index and wraps
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = W'((int'(rr_ptr_q) + 1 + i) % N);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            rr_ptr_q <= W'(N - 1);
        else if (accept)
            rr_ptr_q <= code_q;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending_q[i]) sel = W'(i);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (state_q == IDLE) begin
                if (|pending_q) begin
                    code_q  <= sel;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
            end else if (ready_i) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end
        end
    end

    assign code_o    = code_q;
    assign valid_o   = valid_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
endmodule

// File: tb/tb_onehot_event_encoder.sv
// tb_onehot_event_encoder: scoreboard-driven bench for onehot_event_encoder
module tb_onehot_event_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       ready = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_code;

    onehot_event_encoder #(.N(8), .W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_i(ready),
        .code_o(code), .valid_o(valid), .pending_o(pending), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // inputs change 1 unit after posedge, so at negedge valid & ready predicts the next acceptance
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got code %0d with nothing expected", code);
            end else begin
                exp_code = exp_q.pop_front();
                if (code !== exp_code) begin
                    errors++;
                    $display("FAIL sb_code got %0d exp %0d", code, exp_code);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pending, valid, code, overrun} !== 13'd0) begin
                errors++;
                $display("FAIL reset_state cyc %0d got pend=%h v=%b c=%0d ov=%b exp all 0", i, pending, valid, code, overrun);
            end
        end
        req   = '0;
        ready = 1'b0;
        rst_n = 1'b1;
        tick(2);
        checks++;
        if ({pending, valid, overrun} !== 10'd0) begin
            errors++;
            $display("FAIL reset_release got pend=%h v=%b ov=%b exp 0", pending, valid, overrun);
        end
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1;
        req   = 8'h20;
        exp_q.push_back(3'd5);
        tick();
        req = '0;
        checks++;
        if (pending !== 8'h20 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latch got pend=%h v=%b exp 20 0", pending, valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 3'd5) begin
            errors++;
            $display("FAIL single_offer got v=%b c=%0d exp 1 5", valid, code);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL single_done got v=%b pend=%h exp 0 00", valid, pending);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL single_once got v=%b exp 0", valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h0A;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        tick();
        req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || code !== 3'd1 || pending !== 8'h0A) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b c=%0d pend=%h exp 1 1 0a", i, valid, code, pending);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h08) begin
            errors++;
            $display("FAIL bp_accept1 got v=%b pend=%h exp 0 08", valid, pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 3'd3) begin
            errors++;
            $display("FAIL bp_offer3 got v=%b c=%0d exp 1 3", valid, code);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_final got v=%b pend=%h ov=%b exp 0 00 0", valid, pending, overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        req = 8'h04;
        tick();
        req = '0;
        tick();
        checks++;
        if (overrun !== 1'b0 || valid !== 1'b1 || code !== 3'd2) begin
            errors++;
            $display("FAIL ovr_pre got ov=%b v=%b c=%0d exp 0 1 2", overrun, valid, code);
        end
        req = 8'h04;
        tick();
        req = '0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got %b exp 1", overrun);
        end
        exp_q.push_back(3'd2);
        ready = 1'b1;
        tick(2);
        checks++;
        if (overrun !== 1'b1 || pending !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky got ov=%b pend=%h v=%b exp 1 00 0", overrun, pending, valid);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        req = 8'h04;
        tick();
        req = '0;
        tick();
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        ready = 1'b1;
        req   = 8'h04;
        tick();
        req = '0;
        checks++;
        if (pending !== 8'h04 || valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL setwins_keep got pend=%h v=%b ov=%b exp 04 0 0", pending, valid, overrun);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 3'd2) begin
            errors++;
            $display("FAIL setwins_reoffer got v=%b c=%0d exp 1 2", valid, code);
        end
        tick();
        checks++;
        if (pending !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL setwins_done got pend=%h ov=%b exp 00 0", pending, overrun);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        exp_q.push_back(3'd0);
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(3'd6);
`else
        exp_q.push_back(3'd0);
`endif
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        ready = 1'b1;
        req   = 8'h41;
        tick();
        req = 8'h01;
        tick(8);
        ready = 1'b0;
        req   = '0;
        checks++;
`ifdef ROUND_ROBIN_EN
        if (pending[6] !== 1'b0) begin
            errors++;
            $display("FAIL arb_rr_served got pend6=%b exp 0", pending[6]);
        end
`else
        if (pending[6] !== 1'b1) begin
            errors++;
            $display("FAIL arb_fixed_starve got pend6=%b exp 1", pending[6]);
        end
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL arb_drained got %0d left exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 8'h10;
        tick();
        req = '0;
        tick();
        checks++;
        if (valid !== 1'b1 || code !== 3'd4) begin
            errors++;
            $display("FAIL rsthold_offer got v=%b c=%0d exp 1 4", valid, code);
        end
        rst_n = 1'b0;
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL rsthold_clear got v=%b pend=%h exp 0 00", valid, pending);
        end
        rst_n = 1'b1;
        ready = 1'b0;
        tick(2);
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL rsthold_after got v=%b pend=%h exp 0 00", valid, pending);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_backpressure();
        test_overrun();
        test_set_wins();
        test_arbitration();
        test_reset_mid_hold();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
